// File: rtl/core_pkg.sv
// Shared fetch-path types and constants: word width, NOP encoding, reset PC default
// and the {pc, inst} entry that travels through the response FIFO and into IF/ID.
package core_pkg;
    localparam int XLEN = 32;
    localparam logic [XLEN-1:0] NOP_INST = 32'h0000_0013;
    localparam logic [XLEN-1:0] RESET_PC_DEFAULT = 32'h0000_0000;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [XLEN-1:0] inst;
    } fetch_entry_t;
endpackage

// File: rtl/fetch_fifo.sv
// Synchronous response buffer for the fetch stage: push/pop/flush with an occupancy count.
// DEPTH must be a power of two so the pointers wrap on their own.
module fetch_fifo
    import core_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         push,
    input  fetch_entry_t push_data,
    input  logic         pop,
    output fetch_entry_t head,
    output logic         empty,
    output logic [CW-1:0] count
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    fetch_entry_t mem [DEPTH];
    logic [AW-1:0] rd_ptr;
    logic [AW-1:0] wr_ptr;
    logic full;

    assign empty = (count == '0);
    assign full = (count == CW'(DEPTH));
    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (rst || flush) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            count <= count + CW'(push) - CW'(pop);
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // Upstream credit accounting must make this impossible.
    push_on_full: assert property (@(posedge clk) disable iff (rst) !(push && full && !flush));
endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC, credit-limited imem requests, response FIFO and the IF/ID register.
// Define FETCH_MISALIGN_EN to trap misaligned redirect targets instead of aligning them.
module fetch_stage
    import core_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = RESET_PC_DEFAULT,
    parameter int FIFO_DEPTH = 2
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            pc_pause,
    input  logic            id_pause,
    input  logic            id_bubble,
    input  logic            redirect_valid,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_resp_valid,
    input  logic [XLEN-1:0] imem_resp_data,
    output logic            id_valid,
    output logic [XLEN-1:0] id_pc,
    output logic [XLEN-1:0] id_inst,
    output logic            id_fetch_exc
);
    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam logic [CW:0] CREDITS = (CW+1)'(FIFO_DEPTH);

    logic [XLEN-1:0] pc;
    logic [XLEN-1:0] target;
    logic [CW-1:0] inflight;
    logic [CW-1:0] drop_cnt;
    logic [CW-1:0] live_cnt;
    logic [CW-1:0] fifo_count;
    logic [CW:0] credit_used;
    logic exc;
    logic accept;
    logic resp_live;
    logic resp_keep;
    logic id_load;
    logic bypass;
    logic fifo_empty;
    logic fifo_push;
    logic fifo_pop;
    fetch_entry_t resp_entry;
    fetch_entry_t fifo_head;

`ifdef FETCH_MISALIGN_EN
    assign target = redirect_pc;

    always_ff @(posedge clk) begin
        if (rst) begin
            exc <= 1'b0;
        end else if (redirect_valid) begin
            exc <= (redirect_pc[1:0] != 2'b00);
        end
    end
`else
    assign target = redirect_pc & {{(XLEN-2){1'b1}}, 2'b00};
    assign exc = 1'b0;
`endif

    assign credit_used = {1'b0, inflight} + {1'b0, fifo_count};
    assign imem_req_valid = !rst && !pc_pause && !redirect_valid && !exc && (credit_used < CREDITS);
    assign imem_req_addr = pc;
    assign accept = imem_req_valid && imem_req_ready;

    // Responses beyond the tracked in-flight count (e.g. after reset) are stale and ignored.
    assign resp_live = imem_resp_valid && (inflight != '0);
    assign resp_keep = resp_live && (drop_cnt == '0) && !redirect_valid;

    // Live requests are consecutive words ending just below pc, so the oldest one's
    // address is recovered from the live count instead of storing a tag per request.
    assign live_cnt = inflight - drop_cnt;
    assign resp_entry = '{pc: pc - (XLEN'(live_cnt) << 2), inst: imem_resp_data};

    assign id_load = !id_bubble && !id_pause && !exc;
    assign bypass = id_load && fifo_empty && resp_keep;
    assign fifo_push = resp_keep && !bypass;
    assign fifo_pop = id_load && !fifo_empty;

    fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst       (rst),
        .flush     (redirect_valid),
        .push      (fifo_push),
        .push_data (resp_entry),
        .pop       (fifo_pop),
        .head      (fifo_head),
        .empty     (fifo_empty),
        .count     (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            pc <= RESET_PC;
            inflight <= '0;
            drop_cnt <= '0;
        end else begin
            if (redirect_valid) begin
                pc <= target;
                drop_cnt <= inflight - CW'(resp_live);
            end else begin
                if (accept) begin
                    pc <= pc + 32'd4;
                end
                if (resp_live && (drop_cnt != '0)) begin
                    drop_cnt <= drop_cnt - 1'b1;
                end
            end
            inflight <= inflight + CW'(accept) - CW'(resp_live);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            id_valid <= 1'b0;
            id_pc <= '0;
            id_inst <= NOP_INST;
            id_fetch_exc <= 1'b0;
        end else if (id_bubble) begin
            id_valid <= 1'b0;
            id_inst <= NOP_INST;
            id_fetch_exc <= 1'b0;
        end else if (!id_pause) begin
            if (exc) begin
                id_valid <= 1'b1;
                id_pc <= pc;
                id_inst <= NOP_INST;
                id_fetch_exc <= 1'b1;
            end else if (!fifo_empty) begin
                id_valid <= 1'b1;
                id_pc <= fifo_head.pc;
                id_inst <= fifo_head.inst;
                id_fetch_exc <= 1'b0;
            end else if (bypass) begin
                id_valid <= 1'b1;
                id_pc <= resp_entry.pc;
                id_inst <= resp_entry.inst;
                id_fetch_exc <= 1'b0;
            end else begin
                id_valid <= 1'b0;
                id_inst <= NOP_INST;
                id_fetch_exc <= 1'b0;
            end
        end
    end
endmodule
